// File: rtl/mem_resp_demux.sv
// mem_resp_demux: in-order tag queue that steers memory read responses back to port A or port B.
// Optional MEM_RESP_DEMUX_REG_OUT_EN registers the port outputs for one added cycle of latency.
`default_nettype none

module mem_resp_demux #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_fire,
    input  logic                     req_sel,
    output logic                     req_ready,
    input  logic                     resp_valid,
    input  logic [N-1:0]             resp_data,
    output logic                     a_valid,
    output logic [N-1:0]             a_data,
    output logic                     b_valid,
    output logic [N-1:0]             b_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0] tags_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;

    logic full, empty, bypass, store, pop, route_valid, route_tag;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    // Same-cycle request and response on an empty queue route straight through.
    assign bypass = empty & req_fire & resp_valid;
    assign store  = req_fire & ~full & ~bypass;
    assign pop    = resp_valid & ~empty;

    assign route_valid = pop | bypass;
    assign route_tag   = bypass ? req_sel : tags_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (store && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !store) begin
            count_d = count_q - CW'(1);
        end
    end

    // Overflow is judged against the registered count, so a same-cycle pop does not excuse it.
    always_comb begin
        err_d = err_q;
        if ((req_fire && full) || (resp_valid && empty && !req_fire)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tags_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (store) begin
                tags_q[wr_ptr_q] <= req_sel;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    logic         rt_a_valid, rt_b_valid;
    logic [N-1:0] rt_a_data, rt_b_data;

    always_comb begin
        rt_a_valid = 1'b0;
        rt_a_data  = '0;
        rt_b_valid = 1'b0;
        rt_b_data  = '0;
        if (route_valid) begin
            if (route_tag) begin
                rt_b_valid = 1'b1;
                rt_b_data  = resp_data;
            end else begin
                rt_a_valid = 1'b1;
                rt_a_data  = resp_data;
            end
        end
    end

`ifdef MEM_RESP_DEMUX_REG_OUT_EN
    logic         a_valid_q, b_valid_q;
    logic [N-1:0] a_data_q, b_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_valid_q <= 1'b0;
            b_data_q  <= '0;
        end else begin
            a_valid_q <= rt_a_valid;
            a_data_q  <= rt_a_data;
            b_valid_q <= rt_b_valid;
            b_data_q  <= rt_b_data;
        end
    end

    assign a_valid = a_valid_q;
    assign a_data  = a_data_q;
    assign b_valid = b_valid_q;
    assign b_data  = b_data_q;
`else
    assign a_valid = rt_a_valid;
    assign a_data  = rt_a_data;
    assign b_valid = rt_b_valid;
    assign b_data  = rt_b_data;
`endif

    assign req_ready = ~full;
    assign count     = count_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: doc/mem_resp_demux.md
Name: mem_resp_demux

Overview:
- Return-path counterpart to the processor's 2:1 request multiplexer on the shared single-ported memory.
- Records the source of every accepted memory request (0 = port A / instruction fetch, 1 = port B / data access) in an in-order tag queue.
- Steers each returning read response to the port that issued it.
- Sits between the unified memory and the fetch/load-store units.

Parameters:
- N, 32, data width of responses
- DEPTH, 4, max outstanding requests; power of 2, >= 2

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_fire  input  1  memory accepted a request this cycle
- req_sel  input  1  source of that request: 0 = A, 1 = B
- req_ready  output  1  tag queue can take a request (count < DEPTH)
- resp_valid  input  1  memory returns a response this cycle
- resp_data  input  N  response data
- a_valid  output  1  response for port A
- a_data  output  N  response data to A
- b_valid  output  1  response for port B
- b_data  output  N  response data to B
- count  output  $clog2(DEPTH)+1  outstanding requests
- err  output  1  sticky protocol error

Behaviour:
- Reset (rst sampled high at a clk edge):
  - count = 0, err = 0, read and write pointers = 0, queue contents don't-care.
  - a_valid = b_valid = 0, a_data = b_data = 0; req_ready = 1 in the cycle after reset.
  - Reset mid-operation discards all pending tags; responses already in flight are then spurious (see below).
- Tag queue: circular buffer of DEPTH 1-bit entries.
  - Write pointer and read pointer are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - count tracks occupancy, 0..DEPTH.
- Push: when req_fire=1 and count<DEPTH, req_sel is written at the write pointer and the write pointer increments.
- Pop: when resp_valid=1 and count>0, the entry at the read pointer is the routing tag and the read pointer increments.
- Routing (default build, combinational, zero added latency):
  - Tag 0: a_valid = 1 and a_data = resp_data; b_valid = 0 and b_data = 0.
  - Tag 1: b_valid = 1 and b_data = resp_data; a_valid = 0 and a_data = 0.
  - At most one of a_valid and b_valid is high in any cycle.
  - Ports have no backpressure; a consumer must take data in the cycle it is valid.
- Count update per cycle:
  - push only: +1; pop only: -1.
  - push and pop together with count>0: count unchanged, both pointers advance.
- Empty bypass: if count=0 and req_fire=1 and resp_valid=1 in the same cycle, the response is routed by req_sel directly; nothing is stored and count stays 0.
- Overflow: req_fire=1 while count=DEPTH sets err and the request tag is dropped. This applies even when a pop occurs in the same cycle, because req_ready was low. The pop still proceeds normally.
- Spurious response: resp_valid=1 while count=0 without a bypass sets err; a_valid = b_valid = 0.
- err is sticky; only rst clears it.
- req_ready = (count < DEPTH), combinational from the count register.

Optional Feature:
- Macro: MEM_RESP_DEMUX_REG_OUT_EN.
- When defined:
  - a_valid, a_data, b_valid and b_data are registered, adding exactly 1 cycle of latency from resp_valid to the port valid.
  - The registers reset to 0 and carry valids for a single cycle only.
  - Queue, count, err and req_ready timing are unchanged.
- When undefined: outputs are combinational as described in Behaviour.

Test Plan:
- Reset, then fire sel 0,1,1 on three consecutive cycles, then resp_valid with data 0x11, 0x22, 0x33 -> a_valid with 0x11, then b_valid with 0x22 and 0x33; count goes 1,2,3 then 2,1,0; err = 0.
- Fill DEPTH=4 (sel 1,0,1,0) -> req_ready = 0 at count 4. Fifth fire -> err = 1. Four responses then route B,A,B,A.
- Steady stream at count=2 with push and pop every cycle for 10 cycles -> count stays 2, pointers wrap, routing order matches push order.
- count = 0 with req_fire=1 (sel=1) and resp_valid=1 (data 0xDEADBEEF) together -> b_valid = 1 with b_data 0xDEADBEEF; count stays 0; err = 0.
- resp_valid with empty queue and no fire -> no port valid, err = 1. Assert rst with count=3 -> count = 0, err = 0, req_ready = 1 next cycle.
- Build with MEM_RESP_DEMUX_REG_OUT_EN and repeat the first scenario -> identical data at the ports, each one cycle later.
